clk_divider_multi: RTL and testbench
====================================

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 16, the bit width of each divisor and its period counter.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2, the divisor loaded into every channel at reset (2..2^WIDTH-1).
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, NUM_CH bits: per-channel run enable.
REQ-007 SHALL have port sync, input, 1 bit: a one-cycle strobe that phase-aligns all channels.
REQ-008 SHALL have port div_wr, input, 1 bit: divisor write strobe.
REQ-009 SHALL have port div_ch, input, $clog2(NUM_CH) bits (min 1): the channel index for the divisor write.
REQ-010 SHALL have port div_val, input, WIDTH bits: the divisor value to write.
REQ-011 SHALL have port clk_out, output, NUM_CH bits: the per-channel divided square wave.
REQ-012 SHALL have port tick, output, NUM_CH bits: the per-channel one-cycle end-of-period strobe.

Function
REQ-013 SHALL hold per channel i an active divisor div_act[i], a pending divisor div_pend[i] and a counter cnt[i], all WIDTH bits.
REQ-014 SHALL clamp a written div_val of 0 or 1 to 2 before storing it.
REQ-015 SHALL apply div_wr with div_ch >= NUM_CH as a no-op.
REQ-016 SHALL, on div_wr to channel i, load div_pend[i] in the next cycle; when en[i]=0, div_act[i] SHALL also be loaded in that same cycle.
REQ-017 SHALL, while en[i]=1, count as: cnt[i] <= 0 if cnt[i] == div_act[i]-1, else cnt[i]+1.
REQ-018 SHALL, on wrap, load div_act[i] <= div_pend[i], so a new divisor takes effect only at a period boundary and the output stays glitch-free.
REQ-019 SHALL, when a div_wr lands in the same cycle as a wrap, use the written value for the period that starts in the next cycle.
REQ-020 SHALL drive clk_out[i] as a register equal each cycle to (cnt[i] >= div_act[i]/2, integer floor), giving floor(D/2) cycles low followed by ceil(D/2) cycles high.
REQ-021 SHALL drive tick[i] as a register equal each cycle to (en[i] and cnt[i] == div_act[i]-1), asserting exactly one cycle per period.
REQ-022 SHALL, while en[i]=0, force cnt[i] to 0 and hold clk_out[i]=0 and tick[i]=0; when en[i] rises, the first period SHALL start at cnt=0.
REQ-023 SHALL, on sync=1, force cnt to 0 on every channel in the next cycle.
REQ-024 SHALL treat sync as a wrap: div_act <= div_pend on every enabled channel.
REQ-025 SHALL give sync priority over a simultaneous wrap.
REQ-026 SHALL let a same-cycle div_wr update div_pend, and the sync-triggered load SHALL use the value being written.
REQ-027 SHALL keep channels fully independent except for the shared sync and the shared write port.
REQ-028 SHALL give clk_out a period of exactly div_act[i] clk_in cycles in steady state, for any WIDTH.

Reset
REQ-029 SHALL, while rst=1, set every cnt to 0, every div_act and div_pend to DEFAULT_DIV, and clk_out and tick to 0.
REQ-030 SHALL give rst priority over sync, div_wr and en.
REQ-031 SHALL, when rst is asserted mid-period, return the outputs to 0 in the next cycle, without any partial pulse.

Verification
REQ-032 SHALL cover: reset, then en=1 on ch0 with DEFAULT_DIV=2 -> clk_out[0] alternates 0,1 every cycle and tick[0] is high in each cycle that clk_out[0]=1.
REQ-033 SHALL cover: write div_val=5 to ch1 with en[1]=0, then en[1]=1 -> clk_out[1] repeats 0,0,1,1,1 and tick[1] is high on the 5th cycle of each period.
REQ-034 SHALL cover: ch2 running at D=4, write div_val=6 at cnt=1 -> the current period completes as 4 cycles and the following periods are 6 cycles (3 low, 3 high).
REQ-035 SHALL cover: ch0 at D=3 and ch1 at D=7 running, then sync pulsed -> both cnt=0 in the next cycle and both clk_out low, after which ch0 and ch1 rising edges coincide every 21 cycles.
REQ-036 SHALL cover: div_val=0 and div_val=1 writes -> each behaves as D=2, and a write with div_ch=NUM_CH leaves all channels unchanged.
REQ-037 SHALL cover: rst asserted during the high phase of ch3 at D=10 -> clk_out[3]=0, tick[3]=0 and div_act[3]=DEFAULT_DIV in the next cycle.

Source files
------------

// File: rtl/clk_divider_multi_if.sv
// Control and output bundle for the multi-channel clock divider.
// The master drives enables, sync and divisor writes; the slave returns the divided clocks and ticks.
interface clk_divider_multi_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 16
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              div_wr;
   logic [CH_W-1:0]   div_ch;
   logic [WIDTH-1:0]  div_val;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   modport master (
      output en, sync, div_wr, div_ch, div_val,
      input  clk_out, tick
   );

   modport slave (
      input  en, sync, div_wr, div_ch, div_val,
      output clk_out, tick
   );
endinterface

// File: rtl/clk_divider_multi.sv
// NUM_CH independent integer clock dividers sharing one write port and one sync strobe.
// A new divisor is staged as pending and adopted at a period boundary or on sync.
module clk_divider_multi #(
   parameter int NUM_CH      = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                 clk_in,
   input  logic                 rst,
   clk_divider_multi_if.slave   bus
);
   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

   logic [WIDTH-1:0] w_wr_val;

   // Divisors below 2 cannot form a square wave, so they are raised to 2.
   assign w_wr_val = (bus.div_val < DIV_MIN) ? DIV_MIN : bus.div_val;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [WIDTH-1:0] r_cnt;
         logic [WIDTH-1:0] r_div_act;
         logic [WIDTH-1:0] r_div_pend;
         logic             r_clk_out;
         logic             r_tick;

         logic             w_wr_hit;
         logic             w_wrap;
         logic [WIDTH-1:0] w_pend_next;
         logic [WIDTH-1:0] w_act_next;
         logic [WIDTH-1:0] w_cnt_next;

         // Out-of-range channel indices never match, so such writes are dropped.
         assign w_wr_hit = bus.div_wr && (int'(bus.div_ch) == gi);
         assign w_wrap   = bus.en[gi] && (r_cnt == r_div_act - WIDTH'(1));

         always_comb begin
            w_pend_next = r_div_pend;
            w_act_next  = r_div_act;
            w_cnt_next  = r_cnt + WIDTH'(1);
            if (w_wr_hit) begin
               w_pend_next = w_wr_val;
            end
            // Sync and wrap both start a fresh period with the newest pending divisor.
            if (bus.en[gi] && (bus.sync || w_wrap)) begin
               w_act_next = w_pend_next;
            end else if (w_wr_hit && !bus.en[gi]) begin
               w_act_next = w_wr_val;
            end
            if (bus.sync || !bus.en[gi] || w_wrap) begin
               w_cnt_next = '0;
            end
         end

         // Outputs are computed from next-state values so they line up with r_cnt.
         always_ff @(posedge clk_in) begin
            if (rst) begin
               r_cnt      <= '0;
               r_div_act  <= DIV_RST;
               r_div_pend <= DIV_RST;
               r_clk_out  <= 1'b0;
               r_tick     <= 1'b0;
            end else begin
               r_cnt      <= w_cnt_next;
               r_div_act  <= w_act_next;
               r_div_pend <= w_pend_next;
               r_clk_out  <= (w_cnt_next >= (w_act_next >> 1));
               r_tick     <= bus.en[gi] && (w_cnt_next == w_act_next - WIDTH'(1));
            end
         end

         assign bus.clk_out[gi] = r_clk_out;
         assign bus.tick[gi]    = r_tick;
      end
   endgenerate
endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed checks of the multi-channel clock divider against hand-derived waveforms.
module tb_clk_divider_multi;
   localparam int NUM_CH = 5;
   localparam int WIDTH  = 16;

   logic clk_in = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   clk_divider_multi_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

   clk_divider_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.en = '0;
      bus.sync = 1'b0;
      bus.div_wr = 1'b0;
      bus.div_ch = '0;
      bus.div_val = '0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic wr_div(input int ch, input int val);
      bus.div_wr = 1'b1;
      bus.div_ch = 3'(ch);
      bus.div_val = 16'(val);
      cyc();
      bus.div_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = '1;
      bus.sync = 1'b1;
      bus.div_wr = 1'b1;
      bus.div_ch = 3'd0;
      bus.div_val = 16'd7;
      cyc();
      cyc();
      checks++;
      if (bus.clk_out !== 5'b0 || bus.tick !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs clk_out=%b tick=%b expected 00000/00000", bus.clk_out, bus.tick);
      end
      rst = 1'b0;
      bus.sync = 1'b0;
      bus.div_wr = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         checks++;
         if (bus.clk_out !== ((k % 2) ? 5'b11111 : 5'b00000)) begin
            errors++;
            $display("FAIL reset_default_div k=%0d clk_out=%b expected %b", k, bus.clk_out,
                     (k % 2) ? 5'b11111 : 5'b00000);
         end
      end
   endtask

   task automatic test_div2();
      do_reset();
      bus.en = 5'b00001;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         checks++;
         if (bus.clk_out[0] !== 1'(k % 2) || bus.tick[0] !== 1'(k % 2)) begin
            errors++;
            $display("FAIL div2 k=%0d clk_out=%b tick=%b expected %b/%b", k, bus.clk_out[0], bus.tick[0],
                     1'(k % 2), 1'(k % 2));
         end
      end
   endtask

   task automatic test_div5();
      do_reset();
      wr_div(1, 5);
      bus.en = 5'b00010;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         checks++;
         if (bus.clk_out[1] !== ((k % 5) >= 2) || bus.tick[1] !== ((k % 5) == 4)) begin
            errors++;
            $display("FAIL div5 k=%0d clk_out=%b tick=%b expected %b/%b", k, bus.clk_out[1], bus.tick[1],
                     (k % 5) >= 2, (k % 5) == 4);
         end
      end
   endtask

   task automatic test_change_midperiod();
      logic ec;
      logic et;
      do_reset();
      wr_div(2, 4);
      bus.en = 5'b00100;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k == 1) begin
            bus.div_wr = 1'b1;
            bus.div_ch = 3'd2;
            bus.div_val = 16'd6;
         end else begin
            bus.div_wr = 1'b0;
         end
         ec = (k < 4) ? ((k % 4) >= 2) : (((k - 4) % 6) >= 3);
         et = (k < 4) ? (k == 3) : (((k - 4) % 6) == 5);
         checks++;
         if (bus.clk_out[2] !== ec || bus.tick[2] !== et) begin
            errors++;
            $display("FAIL change_4_to_6 k=%0d clk_out=%b tick=%b expected %b/%b", k, bus.clk_out[2],
                     bus.tick[2], ec, et);
         end
      end
   endtask

   task automatic test_write_at_wrap();
      logic ec;
      do_reset();
      wr_div(4, 4);
      bus.en = 5'b10000;
      cyc();
      cyc();
      cyc();
      bus.div_wr = 1'b1;
      bus.div_ch = 3'd4;
      bus.div_val = 16'd5;
      for (int k = 4; k <= 13; k++) begin
         cyc();
         bus.div_wr = 1'b0;
         ec = ((k - 4) % 5) >= 2;
         checks++;
         if (bus.clk_out[4] !== ec || bus.tick[4] !== (((k - 4) % 5) == 4)) begin
            errors++;
            $display("FAIL write_at_wrap k=%0d clk_out=%b tick=%b expected %b/%b", k, bus.clk_out[4],
                     bus.tick[4], ec, ((k - 4) % 5) == 4);
         end
      end
   endtask

   task automatic test_sync();
      logic p0;
      logic p1;
      int   coincide;
      do_reset();
      wr_div(0, 3);
      wr_div(1, 7);
      bus.en = 5'b00011;
      repeat (5) cyc();
      bus.sync = 1'b1;
      cyc();
      bus.sync = 1'b0;
      checks++;
      if (bus.clk_out[1:0] !== 2'b00 || bus.tick[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL sync_align clk_out=%b tick=%b expected 00/00", bus.clk_out[1:0], bus.tick[1:0]);
      end
      p0 = 1'b0;
      p1 = 1'b0;
      coincide = 0;
      for (int k = 1; k <= 42; k++) begin
         cyc();
         checks++;
         if (bus.clk_out[0] !== ((k % 3) >= 1) || bus.clk_out[1] !== ((k % 7) >= 3)) begin
            errors++;
            $display("FAIL sync_run k=%0d clk_out=%b expected %b%b", k, bus.clk_out[1:0],
                     (k % 7) >= 3, (k % 3) >= 1);
         end
         if (bus.clk_out[0] && !p0 && bus.clk_out[1] && !p1) coincide++;
         p0 = bus.clk_out[0];
         p1 = bus.clk_out[1];
      end
      checks++;
      if (coincide !== 2) begin
         errors++;
         $display("FAIL sync_coincide count=%0d expected 2", coincide);
      end
   endtask

   task automatic test_sync_write();
      do_reset();
      wr_div(4, 4);
      bus.en = 5'b10000;
      cyc();
      cyc();
      bus.sync = 1'b1;
      bus.div_wr = 1'b1;
      bus.div_ch = 3'd4;
      bus.div_val = 16'd3;
      cyc();
      bus.sync = 1'b0;
      bus.div_wr = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         checks++;
         if (bus.clk_out[4] !== ((k % 3) >= 1) || bus.tick[4] !== ((k % 3) == 2)) begin
            errors++;
            $display("FAIL sync_write k=%0d clk_out=%b tick=%b expected %b/%b", k, bus.clk_out[4],
                     bus.tick[4], (k % 3) >= 1, (k % 3) == 2);
         end
      end
   endtask

   task automatic test_clamp_and_bad_ch();
      do_reset();
      wr_div(0, 0);
      wr_div(1, 1);
      wr_div(NUM_CH, 9);
      bus.en = 5'b11111;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         checks++;
         if (bus.clk_out !== ((k % 2) ? 5'b11111 : 5'b00000) || bus.tick !== bus.clk_out) begin
            errors++;
            $display("FAIL clamp_badch k=%0d clk_out=%b tick=%b expected %b", k, bus.clk_out, bus.tick,
                     (k % 2) ? 5'b11111 : 5'b00000);
         end
      end
   endtask

   task automatic test_reset_midperiod();
      do_reset();
      wr_div(3, 10);
      bus.en = 5'b01000;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         checks++;
         if (bus.clk_out[3] !== ((k % 10) >= 5)) begin
            errors++;
            $display("FAIL div10 k=%0d clk_out=%b expected %b", k, bus.clk_out[3], (k % 10) >= 5);
         end
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (bus.clk_out[3] !== 1'b0 || bus.tick[3] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid clk_out=%b tick=%b expected 0/0", bus.clk_out[3], bus.tick[3]);
      end
      for (int k = 1; k <= 4; k++) begin
         cyc();
         checks++;
         if (bus.clk_out[3] !== 1'(k % 2)) begin
            errors++;
            $display("FAIL rst_mid_default k=%0d clk_out=%b expected %b", k, bus.clk_out[3], 1'(k % 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_div2();
      test_div5();
      test_change_midperiod();
      test_write_at_wrap();
      test_sync();
      test_sync_write();
      test_clamp_and_bad_ch();
      test_reset_midperiod();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
